// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl: write-domain pointer logic for the async FIFO.
// Owns the binary/Gray write pointer and derives full, almost-full, level and overflow.
module fifo_wr_ptr_ctrl #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int AF_THRESHOLD  = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     W_INC,
    input  logic                     CLR_OVF,
    input  logic [ADDRESS_WIDTH:0]   RD_PTR_SYNC,
    output logic                     W_EN,
    output logic [ADDRESS_WIDTH-1:0] WR_ADDR,
    output logic [ADDRESS_WIDTH:0]   WR_PTR_GRAY,
    output logic                     W_FULL,
    output logic                     W_ALMOST_FULL,
    output logic [ADDRESS_WIDTH:0]   W_LEVEL,
    output logic                     W_OVERFLOW
);
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW:0] AF = AF_THRESHOLD[AW:0];

    logic [AW:0] wbin, wbin_next, gnext, rbin, level_next;

    assign W_EN       = W_INC & ~W_FULL;
    assign WR_ADDR    = wbin[AW-1:0];
    assign wbin_next  = wbin + {{AW{1'b0}}, W_EN};
    assign gnext      = wbin_next ^ (wbin_next >> 1);
    assign level_next = wbin_next - rbin;

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i <= AW; i++) begin : g_rbin
        assign rbin[i] = ^(RD_PTR_SYNC >> i);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbin          <= '0;
            WR_PTR_GRAY   <= '0;
            W_FULL        <= 1'b0;
            W_ALMOST_FULL <= 1'b0;
            W_LEVEL       <= '0;
            W_OVERFLOW    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            WR_PTR_GRAY   <= gnext;
            W_FULL        <= gnext == {~RD_PTR_SYNC[AW:AW-1], RD_PTR_SYNC[AW-2:0]};
            W_ALMOST_FULL <= level_next >= AF;
            W_LEVEL       <= level_next;
            if (W_INC & W_FULL)
                W_OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                W_OVERFLOW <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb_fifo_wr_ptr_ctrl: randomized and directed checks against a count-based FIFO model.
module tb_fifo_wr_ptr_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       W_INC = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic [3:0] RD_PTR_SYNC = '0;
    logic       W_EN;
    logic [2:0] WR_ADDR;
    logic [3:0] WR_PTR_GRAY;
    logic       W_FULL;
    logic       W_ALMOST_FULL;
    logic [3:0] W_LEVEL;
    logic       W_OVERFLOW;

    int errors = 0;
    int checks = 0;

    // model: unbounded write/read counts, everything else derived arithmetically
    int m_wr = 0;
    int m_level = 0;
    bit m_ovf = 1'b0;
    logic [3:0] prev_gray;

    fifo_wr_ptr_ctrl #(.ADDRESS_WIDTH(3), .AF_THRESHOLD(6)) dut (
        .CLK(CLK), .RST(RST), .W_INC(W_INC), .CLR_OVF(CLR_OVF),
        .RD_PTR_SYNC(RD_PTR_SYNC), .W_EN(W_EN), .WR_ADDR(WR_ADDR),
        .WR_PTR_GRAY(WR_PTR_GRAY), .W_FULL(W_FULL), .W_ALMOST_FULL(W_ALMOST_FULL),
        .W_LEVEL(W_LEVEL), .W_OVERFLOW(W_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic int m16(input int x);
        return ((x % 16) + 16) % 16;
    endfunction

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(m16(b));
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs();
        check("gray", WR_PTR_GRAY, gray(m_wr));
        check("level", W_LEVEL, m_level);
        check("full", W_FULL, m_level == 8);
        check("afull", W_ALMOST_FULL, m_level >= 6);
        check("ovf", W_OVERFLOW, m_ovf);
        check("addr", WR_ADDR, m16(m_wr) % 8);
    endtask

    // one cycle: drive inputs, check W_EN before the edge, update model, check after
    task automatic cyc(input bit inc, input bit clr, input int rd);
        bit full, en;
        W_INC = inc;
        CLR_OVF = clr;
        RD_PTR_SYNC = gray(rd);
        full = (m_level == 8);
        en = inc && !full;
        #1;
        check("w_en", W_EN, en);
        @(posedge CLK);
        if (inc && full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_wr += int'(en);
        m_level = m16(m_wr - rd);
        #1;
        check_regs();
    endtask

    task automatic reset_mid_cycle();
        #2;
        W_INC = 1'b1;
        RST = 1'b1;
        #1;
        m_wr = 0; m_level = 0; m_ovf = 1'b0;
        check_regs();
        check("rst_w_en", W_EN, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        check_regs();
        RST = 1'b0;
    endtask

    initial begin
        int rd;
        repeat (2) @(posedge CLK);
        #1;
        check_regs();
        RST = 1'b0;
        // reset mid-burst at level 5
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        check("lvl5", W_LEVEL, 5);
        reset_mid_cycle();
        // fill then overflow
        for (int i = 0; i < 10; i++) cyc(1, 0, 0);
        // drain one, then refill
        cyc(0, 0, 1);
        check("drain_lvl", W_LEVEL, 7);
        cyc(1, 0, 1);
        // overflow clear: set wins over simultaneous clear
        cyc(0, 1, 1);
        cyc(1, 1, 1);
        cyc(0, 1, 1);
        // wrap with read pointer trailing by two
        reset_mid_cycle();
        prev_gray = WR_PTR_GRAY;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, m_wr - 1);
            check("ham", $countones(prev_gray ^ WR_PTR_GRAY) <= 1, 1);
            prev_gray = WR_PTR_GRAY;
        end
        // random traffic with read pointer never passing the write pointer
        rd = m_wr - 2;
        for (int i = 0; i < 400; i++) begin
            if (rd < m_wr && ($urandom % 3) != 0) rd++;
            cyc(($urandom % 4) != 0, ($urandom % 8) == 0, rd);
            check("ham_r", $countones(prev_gray ^ WR_PTR_GRAY) <= 1, 1);
            prev_gray = WR_PTR_GRAY;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
